symbol_plotter: RTL and testbench

SYMBOL_PLOTTER -- requirements
Module: symbol_plotter

---
 rtl/symbol_plotter_if.sv | 47 ++++
 rtl/symbol_plotter.sv | 167 ++++++++++++++++
 tb/tb_symbol_plotter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/symbol_plotter_if.sv
`default_nettype none
// ============================================================================
// Module      : symbol_plotter_if
// Description : Bundles the draw request, point-table ROM port and pixel
//               output of the symbol plotter.
//               master : requester side. It drives the request and answers
//                        ROM reads.
//               slave  : the plotter itself.
//   start, sym_sel, x, y, colour_in, erase : draw request
//   rom_addr / rom_data                    : registered point-table ROM
//   plot, xout, yout, colour               : pixel write strobe + pixel
//   busy, done                             : draw status
// Revision    : 1.0 - initial release
// ============================================================================
interface symbol_plotter_if #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int OFS_W = 4,
  parameter int SYM_W = 2,
  parameter int IDX_W = 6
) ();
  logic                   start;
  logic [SYM_W-1:0]       sym_sel;
  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic [2:0]             colour_in;
  logic                   erase;
  logic [SYM_W+IDX_W-1:0] rom_addr;
  logic [2*OFS_W:0]       rom_data;
  logic                   plot;
  logic [X_W-1:0]         xout;
  logic [Y_W-1:0]         yout;
  logic [2:0]             colour;
  logic                   busy;
  logic                   done;

  modport master (
    output start, sym_sel, x, y, colour_in, erase, rom_data,
    input  rom_addr, plot, xout, yout, colour, busy, done
  );

  modport slave (
    input  start, sym_sel, x, y, colour_in, erase, rom_data,
    output rom_addr, plot, xout, yout, colour, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/symbol_plotter.sv
`default_nettype none
// ============================================================================
// Module      : symbol_plotter
// Description : Walks a symbol's point table in a registered ROM. It issues
//               one address per cycle and emits one clipped pixel per
//               returned point. It stops on the point flagged last, or at
//               MAX_POINTS points.
// Ports       : clk   - clock, all state on the rising edge
//               reset - synchronous active-high reset
//               bus   - symbol_plotter_if.slave (request, ROM, pixel, status)
// Revision    : 1.0 - initial release
// ============================================================================
module symbol_plotter #(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int OFS_W      = 4,
  parameter int SYM_W      = 2,
  parameter int IDX_W      = 6,
  parameter int MAX_POINTS = 37,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119
) (
  input  logic             clk,
  input  logic             reset,
  symbol_plotter_if.slave  bus
);

  localparam logic [X_W:0]       c_x_max    = X_MAX[X_W:0];
  localparam logic [Y_W:0]       c_y_max    = Y_MAX[Y_W:0];
  localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(MAX_POINTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  // Draw parameters latched at start
  logic [SYM_W-1:0]     r_sym;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic [2:0]           r_col;

  // r_idx is the address index issued this cycle. r_pidx is the index
  // whose data is on rom_data now, and r_vld marks it as a real issue.
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_pidx;
  logic                 r_vld;

  logic                 r_plot;
  logic [X_W-1:0]       r_xout;
  logic [Y_W-1:0]       r_yout;
  logic [2:0]           r_colour;

  logic                 w_last;
  logic [OFS_W-1:0]     w_xoff;
  logic [OFS_W-1:0]     w_yoff;
  logic [X_W:0]         w_xsum;
  logic [Y_W:0]         w_ysum;
  logic                 w_start;
  logic                 w_proc;
  logic                 w_final;
  logic                 w_clip;

  assign w_last  = bus.rom_data[2*OFS_W];
  assign w_xoff  = bus.rom_data[2*OFS_W-1:OFS_W];
  assign w_yoff  = bus.rom_data[OFS_W-1:0];

  // Sums are kept one bit wider so clipping sees a wrap as off-screen.
  assign w_xsum  = {1'b0, r_x} + (X_W+1)'(w_xoff);
  assign w_ysum  = {1'b0, r_y} + (Y_W+1)'(w_yoff);
  assign w_clip  = (w_xsum > c_x_max) || (w_ysum > c_y_max);

  assign w_start = (r_state == S_IDLE) && bus.start;
  assign w_proc  = (r_state == S_RUN) && r_vld;
  assign w_final = w_proc && (w_last || (r_pidx == c_last_idx));

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.rom_addr = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.busy     = 1'b1;
        bus.rom_addr = {r_sym, r_idx};
        if (w_final) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.busy    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: latch request, walk indices, register pixel outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sym    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_col    <= '0;
      r_idx    <= '0;
      r_pidx   <= '0;
      r_vld    <= 1'b0;
      r_plot   <= 1'b0;
      r_xout   <= '0;
      r_yout   <= '0;
      r_colour <= '0;
    end else begin
      if (w_start) begin
        r_sym <= bus.sym_sel;
        r_x   <= bus.x;
        r_y   <= bus.y;
        r_col <= bus.erase ? 3'b000 : bus.colour_in;
        r_idx <= '0;
      end

      if (r_state == S_RUN) begin
        r_pidx <= r_idx;
        r_idx  <= r_idx + 1'b1;
      end

      // The address issued alongside the final point is dropped here.
      r_vld  <= (r_state == S_RUN) && !w_final;

      r_plot <= w_proc && !w_clip;
      if (w_proc) begin
        r_xout   <= w_xsum[X_W-1:0];
        r_yout   <= w_ysum[Y_W-1:0];
        r_colour <= r_col;
      end
    end
  end

  assign bus.plot   = r_plot;
  assign bus.xout   = r_xout;
  assign bus.yout   = r_yout;
  assign bus.colour = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_symbol_plotter.sv
`default_nettype none
// ============================================================================
// Module      : tb_symbol_plotter
// Description : Self-checking bench for symbol_plotter. A registered ROM
//               model supplies the point tables. A point-list model gives
//               the expected pixels and the expected done timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_symbol_plotter;

  localparam int X_W = 8, Y_W = 7, OFS_W = 4, SYM_W = 2, IDX_W = 6;
  localparam int MAXP = 37, X_MAX = 159, Y_MAX = 119;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  symbol_plotter_if #(.X_W(X_W), .Y_W(Y_W), .OFS_W(OFS_W), .SYM_W(SYM_W), .IDX_W(IDX_W)) bus ();

  symbol_plotter #(
    .X_W(X_W), .Y_W(Y_W), .OFS_W(OFS_W), .SYM_W(SYM_W), .IDX_W(IDX_W),
    .MAX_POINTS(MAXP), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Point tables {last, xoff, yoff}, read with one cycle of latency
  logic [2*OFS_W:0] rom [0:(1<<SYM_W)-1][0:(1<<IDX_W)-1];
  always @(posedge clk)
    bus.rom_data <= rom[bus.rom_addr[SYM_W+IDX_W-1:IDX_W]][bus.rom_addr[IDX_W-1:0]];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: the list of points a draw visits
  int   m_n;
  int   m_x   [0:63];
  int   m_y   [0:63];
  logic m_vis [0:63];

  function automatic void model(input int sym, input int ox, input int oy);
    m_n = 0;
    for (int k = 0; k < MAXP; k++) begin
      int xo, yo, sx, sy;
      xo = int'(rom[sym][k][2*OFS_W-1:OFS_W]);
      yo = int'(rom[sym][k][OFS_W-1:0]);
      sx = ox + xo;
      sy = oy + yo;
      m_x[k]   = sx % (1 << X_W);
      m_y[k]   = sy % (1 << Y_W);
      m_vis[k] = (sx <= X_MAX) && (sy <= Y_MAX);
      m_n++;
      if (rom[sym][k][2*OFS_W]) break;
    end
  endfunction

  function automatic int model_visible();
    int c = 0;
    for (int k = 0; k < m_n; k++) if (m_vis[k]) c++;
    return c;
  endfunction

  task automatic issue(input int sym, input int ox, input int oy, input int col, input int er);
    bus.start     = 1'b1;
    bus.sym_sel   = SYM_W'(sym);
    bus.x         = X_W'(ox);
    bus.y         = Y_W'(oy);
    bus.colour_in = 3'(col);
    bus.erase     = er[0];
  endtask

  // One full draw, checked every cycle against the model
  task automatic do_draw(input int sym, input int ox, input int oy, input int col,
                         input int er, output int np, output int de);
    int ecol;
    model(sym, ox, oy);
    ecol = (er != 0) ? 0 : col;
    np = 0;
    de = -1;
    issue(sym, ox, oy, col, er);
    step();                                   // edge 0
    bus.start     = 1'b0;
    bus.sym_sel   = SYM_W'($urandom);         // changes mid-draw must not matter
    bus.x         = X_W'($urandom);
    bus.y         = Y_W'($urandom);
    bus.colour_in = 3'($urandom);
    bus.erase     = 1'($urandom);
    chk("busy_e0", 32'(bus.busy), 1);
    chk("addr_e0", 32'(bus.rom_addr), 32'(sym * 64));
    chk("plot_e0", 32'(bus.plot), 0);
    for (int e = 1; e <= m_n + 3; e++) begin
      step();
      if (bus.plot) np++;
      if (bus.done && de < 0) de = e;
      if (e >= 2 && e <= m_n + 1) begin
        chk("plot_pt", 32'(bus.plot), 32'(m_vis[e-2]));
        chk("xout_pt", 32'(bus.xout), 32'(m_x[e-2]));
        chk("yout_pt", 32'(bus.yout), 32'(m_y[e-2]));
        if (m_vis[e-2]) chk("colour_pt", 32'(bus.colour), 32'(ecol));
      end else begin
        chk("plot_idle", 32'(bus.plot), 0);
      end
      if (e <= m_n) chk("rom_addr", 32'(bus.rom_addr), 32'(sym * 64 + e));
      chk("busy", 32'(bus.busy), 32'(e <= m_n + 1));
      chk("done", 32'(bus.done), 32'(e == m_n + 2));
    end
  endtask

  typedef struct {
    int sym;
    int ox;
    int oy;
    int col;
    int er;
    int exp_plots;
    int exp_done;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int np, de, dcnt;

    vecs[0] = '{1, 10, 20, 3, 0, 3, 5};      // basic three-point symbol
    vecs[1] = '{1, 10, 20, 3, 1, 3, 5};      // same, erase
    vecs[2] = '{2, 155, 115, 5, 0, 2, 6};    // clipping at both edges
    vecs[3] = '{3, 0, 0, 7, 0, 37, 39};      // no last flag: point cap

    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 64; k++)
        rom[s][k] = {1'b0, 4'($urandom), 4'($urandom)};
    rom[0][10][2*OFS_W] = 1'b1;
    rom[1][0] = {1'b0, 4'd3, 4'd7};
    rom[1][1] = {1'b0, 4'd3, 4'd9};
    rom[1][2] = {1'b1, 4'd2, 4'd8};
    rom[2][0] = {1'b0, 4'd4, 4'd0};
    rom[2][1] = {1'b0, 4'd5, 4'd0};
    rom[2][2] = {1'b0, 4'd0, 4'd4};
    rom[2][3] = {1'b1, 4'd0, 4'd5};

    reset = 1'b1;
    bus.start = 1'b0; bus.sym_sel = '0; bus.x = '0; bus.y = '0;
    bus.colour_in = '0; bus.erase = 1'b0;
    step();
    step();
    chk("rst_plot",   32'(bus.plot), 0);
    chk("rst_xout",   32'(bus.xout), 0);
    chk("rst_yout",   32'(bus.yout), 0);
    chk("rst_colour", 32'(bus.colour), 0);
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_done",   32'(bus.done), 0);
    chk("rst_addr",   32'(bus.rom_addr), 0);
    reset = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < 4; i++) begin
      do_draw(vecs[i].sym, vecs[i].ox, vecs[i].oy, vecs[i].col, vecs[i].er, np, de);
      chk("vec_plots", 32'(np), 32'(vecs[i].exp_plots));
      chk("vec_done",  32'(de), 32'(vecs[i].exp_done));
    end

    // Randomized draws
    for (int t = 0; t < 10; t++) begin
      int sym, ox, oy;
      sym = int'($urandom_range(0, 3));
      ox  = int'($urandom_range(0, 255));
      oy  = int'($urandom_range(0, 127));
      do_draw(sym, ox, oy, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), np, de);
      model(sym, ox, oy);
      chk("rnd_plots", 32'(np), 32'(model_visible()));
      chk("rnd_done",  32'(de), 32'(m_n + 2));
    end

    // start mid-draw (edge 3) and in the DONE cycle (edge 6) are ignored
    issue(1, 10, 20, 3, 0);
    step();
    dcnt = 0;
    for (int e = 1; e <= 10; e++) begin
      bus.start = (e == 3 || e == 6);
      step();
      if (bus.done) dcnt++;
      if (e == 5) chk("ign_done5", 32'(bus.done), 1);
      if (e == 7) chk("ign_busy7", 32'(bus.busy), 0);
    end
    chk("ign_donecnt", 32'(dcnt), 1);

    // start in the IDLE cycle right after done is accepted
    issue(1, 10, 20, 3, 0);
    step();
    for (int e = 1; e <= 12; e++) begin
      bus.start = (e == 7);
      step();
      if (e == 5)  chk("b2b_done1", 32'(bus.done), 1);
      if (e == 7)  chk("b2b_busy",  32'(bus.busy), 1);
      if (e == 7)  chk("b2b_addr",  32'(bus.rom_addr), 64);
      if (e == 12) chk("b2b_done2", 32'(bus.done), 1);
    end
    bus.start = 1'b0;
    step();

    // reset at edge 3 of a draw, with start also high
    issue(1, 10, 20, 3, 0);
    step();
    for (int e = 1; e <= 3; e++) begin
      reset     = (e == 3);
      bus.start = (e == 3);
      step();
    end
    chk("abrt_plot",   32'(bus.plot), 0);
    chk("abrt_xout",   32'(bus.xout), 0);
    chk("abrt_yout",   32'(bus.yout), 0);
    chk("abrt_colour", 32'(bus.colour), 0);
    chk("abrt_busy",   32'(bus.busy), 0);
    chk("abrt_done",   32'(bus.done), 0);
    chk("abrt_addr",   32'(bus.rom_addr), 0);
    reset = 1'b0;
    bus.start = 1'b0;
    dcnt = 0;
    for (int e = 4; e <= 10; e++) begin
      step();
      if (bus.done || bus.busy) dcnt++;
    end
    chk("abrt_quiet", 32'(dcnt), 0);
    do_draw(1, 10, 20, 3, 0, np, de);
    chk("abrt_plots", 32'(np), 3);
    chk("abrt_ddone", 32'(de), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
